// File: rtl/pacoblaze_call_stack_if.sv
// Push/pop request and stack status bundle for the PacoBlaze return-address stack.
// The master drives requests; the slave (the stack itself) reports top-of-stack and status.
interface pacoblaze_call_stack_if #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 5
);
  logic                  push;
  logic                  pop;
  logic [WIDTH-1:0]      push_data;
  logic                  clear_err;
  logic [WIDTH-1:0]      top;
  logic [DEPTH_LOG2:0]   count;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output push, pop, push_data, clear_err,
    input  top, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, push_data, clear_err,
    output top, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/pacoblaze_call_stack.sv
// Return-address stack with sticky overflow/underflow flags.
// SATURATE selects wrapping (circular) or ignore-on-illegal boundary behaviour.
module pacoblaze_call_stack #(
  parameter int WIDTH      = 10,
  parameter int DEPTH_LOG2 = 5,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  pacoblaze_call_stack_if.slave    bus
);
  localparam int                    DEPTH     = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  // Storage is never reset; it starts at zero from configuration only.
  logic [WIDTH-1:0]      mem_q [DEPTH] = '{default: '0};

  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d, ptr_m1, wr_addr;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  ovf_set, unf_set, wr_en;
  logic                  empty, full;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_FULL);
  assign ptr_m1 = ptr_q - PTR_ONE;

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    case ({bus.push, bus.pop})
      2'b11: begin
        if (!empty) begin
          // Replace top in place: a call immediately following a return.
          wr_en   = 1'b1;
          wr_addr = ptr_m1;
        end else begin
          wr_en   = 1'b1;
          ptr_d   = ptr_q + PTR_ONE;
          count_d = count_q + CNT_ONE;
          unf_set = 1'b1;
        end
      end
      2'b10: begin
        if (!full) begin
          wr_en   = 1'b1;
          ptr_d   = ptr_q + PTR_ONE;
          count_d = count_q + CNT_ONE;
        end else begin
          ovf_set = 1'b1;
          if (!SATURATE) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + PTR_ONE;
          end
        end
      end
      2'b01: begin
        if (!empty) begin
          ptr_d   = ptr_m1;
          count_d = count_q - CNT_ONE;
        end else begin
          unf_set = 1'b1;
          if (!SATURATE) ptr_d = ptr_m1;
        end
      end
      default: ;
    endcase
    ovf_d = (ovf_q & ~bus.clear_err) | ovf_set;
    unf_d = (unf_q & ~bus.clear_err) | unf_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem_q[wr_addr] <= bus.push_data;
  end

  assign bus.top       = (SATURATE && empty) ? '0 : mem_q[ptr_m1];
  assign bus.count     = count_q;
  assign bus.empty     = empty;
  assign bus.full      = full;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: doc/pacoblaze_call_stack.md
PACOBLAZE_CALL_STACK -- requirements
Module: pacoblaze_call_stack

Interface
REQ-001 Parameter WIDTH, default 10, SHALL set the stored entry width in bits (return address).
REQ-002 Parameter DEPTH_LOG2, default 5, SHALL set the entry count DEPTH = 2**DEPTH_LOG2.
REQ-003 Parameter SATURATE, default 0, SHALL select the boundary mode: 0 = circular (pointer wraps), 1 = saturating (illegal operation ignored).
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 push  input  1  write push_data on top of the stack this cycle.
REQ-007 pop  input  1  remove the top entry this cycle.
REQ-008 push_data  input  WIDTH  entry to push.
REQ-009 clear_err  input  1  clears the sticky overflow and underflow flags.
REQ-010 top  output  WIDTH  current top-of-stack entry, combinational from state.
REQ-011 count  output  DEPTH_LOG2+1  number of valid entries, 0..DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 full  output  1  count == DEPTH.
REQ-014 overflow  output  1  sticky: a push occurred while full.
REQ-015 underflow  output  1  sticky: a pop occurred while empty.

Function
REQ-016 The block SHALL hold DEPTH entries in a single-port-style array, a write pointer ptr (DEPTH_LOG2 bits) and count; top SHALL equal mem[ptr-1] (modulo DEPTH).
REQ-017 Array contents SHALL be zero at configuration and SHALL NOT be cleared by reset.
REQ-018 push only, not full: mem[ptr] <= push_data, ptr <= ptr+1, count <= count+1; new value SHALL appear on top the next cycle.
REQ-019 pop only, not empty: ptr <= ptr-1, count <= count-1; previous entry SHALL appear on top the next cycle.
REQ-020 push and pop together, not empty: replace top; mem[ptr-1] <= push_data, ptr and count unchanged, no flag change, even when full.
REQ-021 push and pop together while empty: SHALL act as a push only and set underflow.
REQ-022 push while full, SATURATE=0: write mem[ptr], ptr wraps to ptr+1 (oldest entry overwritten), count stays DEPTH, overflow set.
REQ-023 push while full, SATURATE=1: array, ptr, count unchanged; overflow set.
REQ-024 pop while empty, SATURATE=0: ptr <= ptr-1 (wrapping), count stays 0, underflow set; top SHALL show the stale wrapped entry.
REQ-025 pop while empty, SATURATE=1: ptr unchanged; underflow set; top SHALL read 0 whenever empty.
REQ-026 clear_err SHALL clear both flags next cycle; a flag-setting event in the same cycle SHALL win (flag stays set).
REQ-027 Neither push nor pop: no state change.
REQ-028 count, ptr and flags SHALL be pure registers; empty/full SHALL derive only from count.

Reset
REQ-029 On reset: ptr = 0, count = 0, overflow = 0, underflow = 0, empty = 1, full = 0; push/pop in the same cycle SHALL be ignored.
REQ-030 Reset asserted mid-sequence SHALL discard all pending entries logically (count 0) without touching array contents.

Verification
REQ-031 Defaults: reset, push 0x101,0x102,0x103 -> count 3, top 0x103; pop -> top 0x102, count 2.
REQ-032 Push/pop same cycle with top 0x102, push_data 0x3FF -> top 0x3FF, count 2 unchanged, flags 0.
REQ-033 SATURATE=0, DEPTH_LOG2=2: push 1..5 -> count 4, full 1, overflow 1, top 5; pop x4 -> tops 4,3,2 then empty with count 0.
REQ-034 SATURATE=1, DEPTH_LOG2=2: push 1..5 -> top 4, overflow 1; pop x5 -> count 0, underflow 1, top 0, ptr 0.
REQ-035 Underflow sticky: pop on empty -> underflow 1; clear_err with simultaneous empty pop -> stays 1; clear_err alone -> 0.
REQ-036 Reset mid-operation at count 3 -> next cycle count 0, empty 1, flags 0; push 0x055 -> top 0x055, count 1.
